// File: rtl/lcd_char_controller_if.sv
// Host-side handshake between a character source and lcd_char_controller.
// The master drives bytes and requests; the slave reports busy and the cursor.
interface lcd_char_controller_if #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = $clog2(COLS);

    logic [7:0]       char_in;
    logic             write;
    logic             clear;
    logic             busy;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;

    modport master (
        output char_in, write, clear,
        input  busy, cursor_row, cursor_col
    );

    modport slave (
        input  char_in, write, clear,
        output busy, cursor_row, cursor_col
    );
endinterface

// File: rtl/lcd_char_controller.sv
// HD44780-class character LCD controller: clock-derived timing, 8/4-bit bus, 1/2/4 rows.
// Optional macro LCD_AUTO_WRAP_EN re-addresses the panel after a column wrap.
module lcd_char_controller #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BUS_WIDTH = 8,
    parameter int ROWS      = 2,
    parameter int COLS      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_char_controller_if.slave host,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = $clog2(COLS);

    function automatic int ns_to_cycles(input longint t_ns);
        longint c;
        c = (t_ns * longint'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
        return (c < 64'd1) ? 1 : int'(c);
    endfunction

    localparam int T_PWR = ns_to_cycles(64'd40_000_000);
    localparam int T_CLR = ns_to_cycles(64'd1_530_000);
    localparam int T_CMD = ns_to_cycles(64'd39_000);
    localparam int T_CYC = ns_to_cycles(64'd1_200);
    localparam int T_E   = ns_to_cycles(64'd140);
    localparam int CNT_W = $clog2(T_PWR + 1) + 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_PWR);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(T_CYC - 1);
    localparam logic [CNT_W-1:0] E_LEN    = CNT_W'(T_E);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic             BUS8     = (BUS_WIDTH == 8);
    localparam logic [7:0] FUNC_CMD = {3'b001, BUS8, (ROWS > 1), 3'b000};

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_SEND,
        S_WAIT,
        S_IDLE
`ifdef LCD_AUTO_WRAP_EN
        , S_ADDR
`endif
    } state_t;

    typedef enum logic [2:0] {
        OP_NIB, OP_FUNC, OP_DISP, OP_CLR, OP_ENTRY, OP_RUN, OP_ADDR
    } op_t;

    state_t           state_reg, state_next;
    op_t              op_reg, op_next;
    logic [7:0]       byte_reg, byte_next;
    logic             rs_reg, rs_next;
    logic             half_reg, half_next;
    logic             single_reg, single_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;

    logic             launch;
    op_t              launch_op;
    logic [7:0]       launch_byte;
    logic             launch_rs;
    logic             launch_single;
    logic [CNT_W-1:0] wait_last;
    logic             in_send;
    logic [7:0]       bus_byte;

    genvar gi;

`ifdef LCD_AUTO_WRAP_EN
    localparam logic [27:0] ROW_BASE = {7'h54, 7'h14, 7'h40, 7'h00};
    logic [6:0] row_base [4];
    for (gi = 0; gi < 4; gi++) begin : g_row_base
        assign row_base[gi] = ROW_BASE[gi*7 +: 7];
    end
`endif

    // Clear/home need the long execution time; everything else uses T_CMD.
    assign wait_last = (!rs_reg && (byte_reg == 8'h01 || byte_reg == 8'h02)) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        byte_next     = byte_reg;
        rs_next       = rs_reg;
        half_next     = half_reg;
        single_next   = single_reg;
        cnt_next      = cnt_reg + 1'b1;
        row_next      = row_reg;
        col_next      = col_reg;
        launch        = 1'b0;
        launch_op     = OP_RUN;
        launch_byte   = 8'h00;
        launch_rs     = 1'b0;
        launch_single = BUS8;

        case (state_reg)
            S_PWR_WAIT: begin
                if (cnt_reg == PWR_LAST) begin
                    launch = 1'b1;
                    if (BUS8) begin
                        launch_op   = OP_FUNC;
                        launch_byte = FUNC_CMD;
                    end else begin
                        launch_op     = OP_NIB;
                        launch_byte   = 8'h20;
                        launch_single = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // The execution wait keeps counting from the last E rise.
                if (cnt_reg == CYC_LAST) begin
                    if (!single_reg && !half_reg) begin
                        half_next = 1'b1;
                        cnt_next  = '0;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == wait_last) begin
                    case (op_reg)
                        OP_NIB:  begin launch = 1'b1; launch_op = OP_FUNC;  launch_byte = FUNC_CMD; end
                        OP_FUNC: begin launch = 1'b1; launch_op = OP_DISP;  launch_byte = 8'h0C; end
                        OP_DISP: begin launch = 1'b1; launch_op = OP_CLR;   launch_byte = 8'h01; end
                        OP_CLR:  begin launch = 1'b1; launch_op = OP_ENTRY; launch_byte = 8'h06; end
                        default: begin
                            state_next = S_IDLE;
`ifdef LCD_AUTO_WRAP_EN
                            // A data write leaving col 0 behind it has just wrapped.
                            if (op_reg == OP_RUN && rs_reg && col_reg == '0)
                                state_next = S_ADDR;
`endif
                        end
                    endcase
                end
            end
`ifdef LCD_AUTO_WRAP_EN
            S_ADDR: begin
                launch      = 1'b1;
                launch_op   = OP_ADDR;
                launch_byte = {1'b1, row_base[2'(row_reg)]};
            end
`endif
            S_IDLE: begin
                cnt_next = cnt_reg;
                if (host.clear) begin
                    launch      = 1'b1;
                    launch_byte = 8'h01;
                    row_next    = '0;
                    col_next    = '0;
                end else if (host.write) begin
                    launch      = 1'b1;
                    launch_byte = host.char_in;
                    launch_rs   = 1'b1;
                    if (col_reg == COL_LAST) begin
                        col_next = '0;
                        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_PWR_WAIT;
        endcase

        if (launch) begin
            state_next  = S_SEND;
            op_next     = launch_op;
            byte_next   = launch_byte;
            rs_next     = launch_rs;
            single_next = launch_single;
            half_next   = 1'b0;
            cnt_next    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_PWR_WAIT;
            op_reg     <= OP_FUNC;
            byte_reg   <= 8'h00;
            rs_reg     <= 1'b0;
            half_reg   <= 1'b0;
            single_reg <= 1'b1;
            cnt_reg    <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            byte_reg   <= byte_next;
            rs_reg     <= rs_next;
            half_reg   <= half_next;
            single_reg <= single_next;
            cnt_reg    <= cnt_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
        end
    end

    assign in_send  = (state_reg == S_SEND);
    assign bus_byte = (!BUS8 && !half_reg) ? {4'h0, byte_reg[7:4]} : byte_reg;

    for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_data
        assign lcd_data[gi] = in_send & bus_byte[gi];
    end

    assign lcd_e           = in_send && (cnt_reg < E_LEN);
    assign lcd_rs          = in_send && rs_reg;
    assign lcd_rw          = 1'b0;
    assign host.busy       = (state_reg != S_IDLE);
    assign host.cursor_row = row_reg;
    assign host.cursor_col = col_reg;
endmodule

// File: tb/tb_lcd_char_controller.sv
// Directed bench for lcd_char_controller at 1 MHz: 8-bit/2-row, 4-bit/2-row and 8-bit/1-row panels.
`timescale 1ns/1ps
module tb_lcd_char_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset8, reset4, reset1;
    logic [7:0] lcd_data8, lcd_data1;
    logic [3:0] lcd_data4;
    logic lcd_rs8, lcd_rw8, lcd_e8, lcd_rs4, lcd_rw4, lcd_e4, lcd_rs1, lcd_rw1, lcd_e1;

    lcd_char_controller_if #(.ROWS(2), .COLS(16)) if8 ();
    lcd_char_controller_if #(.ROWS(2), .COLS(16)) if4 ();
    lcd_char_controller_if #(.ROWS(1), .COLS(8))  if1 ();

    lcd_char_controller #(.CLK_HZ(1_000_000), .BUS_WIDTH(8), .ROWS(2), .COLS(16)) dut8 (
        .clk(clk), .reset(reset8), .host(if8),
        .lcd_data(lcd_data8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(lcd_e8));
    lcd_char_controller #(.CLK_HZ(1_000_000), .BUS_WIDTH(4), .ROWS(2), .COLS(16)) dut4 (
        .clk(clk), .reset(reset4), .host(if4),
        .lcd_data(lcd_data4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4));
    lcd_char_controller #(.CLK_HZ(1_000_000), .BUS_WIDTH(8), .ROWS(1), .COLS(8)) dut1 (
        .clk(clk), .reset(reset1), .host(if1),
        .lcd_data(lcd_data1), .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_e(lcd_e1));

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // E-pulse log: bus value and rs at each rising edge, cycle index, and pulse width.
    logic [7:0] q8_data [$];
    logic       q8_rs [$];
    int         q8_cyc [$];
    int         q8_w [$];
    logic [3:0] q4_data [$];
    logic       q4_rs [$];
    int         q4_cyc [$];
    int         q4_w [$];
    logic [7:0] q1_data [$];
    logic       q1_rs [$];
    logic e8_prev = 1'b0, e4_prev = 1'b0, e1_prev = 1'b0;
    int   w8 = 0, w4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        e8_prev <= lcd_e8;
        e4_prev <= lcd_e4;
        e1_prev <= lcd_e1;
        if (lcd_e8 && !e8_prev) begin
            q8_data.push_back(lcd_data8); q8_rs.push_back(lcd_rs8); q8_cyc.push_back(cyc);
        end
        if (!lcd_e8 && e8_prev) q8_w.push_back(w8);
        w8 <= lcd_e8 ? (e8_prev ? w8 + 1 : 1) : w8;
        if (lcd_e4 && !e4_prev) begin
            q4_data.push_back(lcd_data4); q4_rs.push_back(lcd_rs4); q4_cyc.push_back(cyc);
        end
        if (!lcd_e4 && e4_prev) q4_w.push_back(w4);
        w4 <= lcd_e4 ? (e4_prev ? w4 + 1 : 1) : w4;
        if (lcd_e1 && !e1_prev) begin
            q1_data.push_back(lcd_data1); q1_rs.push_back(lcd_rs1);
        end
    end

    task automatic send8(input logic [7:0] ch, input logic wr, input logic clr);
        int n;
        @(negedge clk);
        if8.char_in = ch; if8.write = wr; if8.clear = clr;
        @(negedge clk);
        if8.write = 1'b0; if8.clear = 1'b0;
        n = 0;
        while (if8.busy === 1'b1 && n < 5000) begin @(negedge clk); n++; end
        tests++;
        if (if8.busy !== 1'b0) begin
            failed++; $display("FAIL send8_done: busy=%b after %0d cycles, expected 0", if8.busy, n);
        end
    endtask

    task automatic send1(input logic [7:0] ch);
        int n;
        @(negedge clk);
        if1.char_in = ch; if1.write = 1'b1;
        @(negedge clk);
        if1.write = 1'b0;
        n = 0;
        while (if1.busy === 1'b1 && n < 5000) begin @(negedge clk); n++; end
        tests++;
        if (if1.busy !== 1'b0) begin
            failed++; $display("FAIL send1_done: busy=%b after %0d cycles, expected 0", if1.busy, n);
        end
    endtask

    task automatic test_reset();
        reset8 = 1'b1; reset4 = 1'b1; reset1 = 1'b1;
        if8.char_in = 8'h00; if8.write = 1'b0; if8.clear = 1'b0;
        if4.char_in = 8'h00; if4.write = 1'b0; if4.clear = 1'b0;
        if1.char_in = 8'h00; if1.write = 1'b0; if1.clear = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({lcd_e8, lcd_rs8, lcd_rw8, if8.busy} !== 4'b0001) begin
            failed++; $display("FAIL reset_ctl8: e/rs/rw/busy=%b expected 0001", {lcd_e8, lcd_rs8, lcd_rw8, if8.busy});
        end
        tests++;
        if ({lcd_data8, if8.cursor_row, if8.cursor_col} !== 13'h0) begin
            failed++; $display("FAIL reset_data8: data=%h row=%0d col=%0d expected 0/0/0", lcd_data8, if8.cursor_row, if8.cursor_col);
        end
        tests++;
        if ({lcd_e4, lcd_rs4, lcd_data4, if4.busy} !== 7'b0000001) begin
            failed++; $display("FAIL reset_4bit: e/rs/data/busy=%b expected 0000001", {lcd_e4, lcd_rs4, lcd_data4, if4.busy});
        end
    endtask

    task automatic test_init();
        logic [7:0] exp8 [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int         gap8 [4] = '{40001, 39, 39, 1530};
        logic [3:0] exp4 [9] = '{4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
        int rel, prev, n, bad, fall;
        @(negedge clk);
        reset8 = 1'b0; reset4 = 1'b0; reset1 = 1'b0;
        rel = cyc;
        bad = 0;
        repeat (40000) begin
            @(negedge clk);
            if (lcd_e8 !== 1'b0 || if8.busy !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL init_pwr_wait: %0d bad cycles, expected 0", bad); end
        n = 0;
        while (if8.busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        fall = cyc;
        tests++;
        if (if8.busy !== 1'b0) begin failed++; $display("FAIL init8_busy: busy=%b expected 0", if8.busy); end
        prev = rel;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= q8_data.size()) begin
                failed++; $display("FAIL init8_cmd%0d: no E pulse, expected %02h", i, exp8[i]);
            end else begin
                if ({q8_rs[i], q8_data[i]} !== {1'b0, exp8[i]}) begin
                    failed++; $display("FAIL init8_cmd%0d: rs=%b data=%02h expected rs=0 data=%02h", i, q8_rs[i], q8_data[i], exp8[i]);
                end
                tests++;
                if (q8_cyc[i] - prev != gap8[i]) begin
                    failed++; $display("FAIL init8_gap%0d: %0d cycles expected %0d", i, q8_cyc[i] - prev, gap8[i]);
                end
                tests++;
                if (i >= q8_w.size() || q8_w[i] != 1) begin
                    failed++; $display("FAIL init8_ewidth%0d: width wrong, expected 1", i);
                end
                prev = q8_cyc[i];
            end
        end
        tests++;
        if (fall - prev != 39) begin failed++; $display("FAIL init8_busy_fall: %0d cycles after last E, expected 39", fall - prev); end
        tests++;
        if ({if8.cursor_row, if8.cursor_col} !== 5'h0) begin
            failed++; $display("FAIL init8_cursor: row=%0d col=%0d expected 0,0", if8.cursor_row, if8.cursor_col);
        end
        n = 0;
        while (if4.busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        tests++;
        if (q4_data.size() != 9 || if4.busy !== 1'b0) begin
            failed++; $display("FAIL init4_count: %0d nibbles busy=%b, expected 9 and 0", q4_data.size(), if4.busy);
        end else begin
            bad = 0;
            for (int i = 0; i < 9; i++) if ({q4_rs[i], q4_data[i]} !== {1'b0, exp4[i]}) bad++;
            tests++;
            if (bad != 0) begin failed++; $display("FAIL init4_seq: %0d wrong nibbles, expected 0", bad); end
            tests++;
            if (q4_cyc[2] - q4_cyc[1] != 2) begin
                failed++; $display("FAIL init4_func_gap: %0d cycles expected 2", q4_cyc[2] - q4_cyc[1]);
            end
        end
    endtask

    task automatic test_write_4bit();
        int n, fall;
        q4_data.delete(); q4_rs.delete(); q4_cyc.delete(); q4_w.delete();
        @(negedge clk);
        if4.char_in = 8'h41; if4.write = 1'b1;
        @(negedge clk);
        if4.write = 1'b0;
        n = 0;
        while (if4.busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        fall = cyc;
        tests++;
        if (q4_data.size() != 2 || q4_w.size() != 2) begin
            failed++; $display("FAIL wr4_count: %0d transfers expected 2", q4_data.size());
        end else begin
            tests++;
            if ({q4_rs[0], q4_data[0], q4_rs[1], q4_data[1]} !== {1'b1, 4'h4, 1'b1, 4'h1}) begin
                failed++; $display("FAIL wr4_nibbles: rs/nib %b/%h %b/%h expected 1/4 1/1", q4_rs[0], q4_data[0], q4_rs[1], q4_data[1]);
            end
            tests++;
            if (q4_cyc[1] - q4_cyc[0] != 2 || q4_w[0] != 1 || q4_w[1] != 1) begin
                failed++; $display("FAIL wr4_timing: gap=%0d w=%0d,%0d expected 2 1,1", q4_cyc[1] - q4_cyc[0], q4_w[0], q4_w[1]);
            end
            tests++;
            if (fall - q4_cyc[1] != 39) begin
                failed++; $display("FAIL wr4_busy: %0d cycles after second E, expected 39", fall - q4_cyc[1]);
            end
        end
        tests++;
        if ({if4.cursor_row, if4.cursor_col} !== {1'b0, 4'd1}) begin
            failed++; $display("FAIL wr4_cursor: row=%0d col=%0d expected 0,1", if4.cursor_row, if4.cursor_col);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_q [$];
        int bad;
        q8_data.delete(); q8_rs.delete(); q8_cyc.delete(); q8_w.delete();
        for (int i = 0; i < 32; i++) begin
            send8(8'h30 + 8'(i), 1'b1, 1'b0);
            exp_q.push_back({1'b1, 8'h30 + 8'(i)});
`ifdef LCD_AUTO_WRAP_EN
            if (i == 15) exp_q.push_back({1'b0, 8'hC0});
            if (i == 31) exp_q.push_back({1'b0, 8'h80});
`endif
            if (i == 14 || i == 15 || i == 31) begin
                tests++;
                if ({if8.cursor_row, if8.cursor_col} !== ((i == 14) ? 5'h0F : (i == 15) ? 5'h10 : 5'h00)) begin
                    failed++; $display("FAIL wrap_cursor%0d: row=%0d col=%0d", i, if8.cursor_row, if8.cursor_col);
                end
            end
        end
        tests++;
        if (q8_data.size() != exp_q.size()) begin
            failed++; $display("FAIL wrap_count: %0d E pulses expected %0d", q8_data.size(), exp_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) if ({q8_rs[i], q8_data[i]} !== exp_q[i]) bad++;
            tests++;
            if (bad != 0) begin failed++; $display("FAIL wrap_seq: %0d wrong transfers, expected 0", bad); end
        end
    endtask

    task automatic test_clear_priority();
        int n;
        repeat (3) send8(8'h61, 1'b1, 1'b0);
        tests++;
        if ({if8.cursor_row, if8.cursor_col} !== 5'h03) begin
            failed++; $display("FAIL clr_pre_cursor: row=%0d col=%0d expected 0,3", if8.cursor_row, if8.cursor_col);
        end
        q8_data.delete(); q8_rs.delete(); q8_cyc.delete(); q8_w.delete();
        @(negedge clk);
        if8.char_in = 8'h55; if8.write = 1'b1; if8.clear = 1'b1;
        @(negedge clk);
        if8.write = 1'b0; if8.clear = 1'b0;
        n = 0;
        while (if8.busy === 1'b1 && n < 3000) begin
            n++;
            if (n == 100) begin if8.char_in = 8'h77; if8.write = 1'b1; end
            else if (n == 101) if8.write = 1'b0;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (n != 1530) begin failed++; $display("FAIL clr_busy_len: %0d cycles expected 1530", n); end
        tests++;
        if (q8_data.size() != 1) begin
            failed++; $display("FAIL clr_count: %0d E pulses expected 1", q8_data.size());
        end else begin
            tests++;
            if ({q8_rs[0], q8_data[0]} !== 9'h001) begin
                failed++; $display("FAIL clr_cmd: rs=%b data=%02h expected 0/01", q8_rs[0], q8_data[0]);
            end
        end
        tests++;
        if ({if8.cursor_row, if8.cursor_col} !== 5'h00) begin
            failed++; $display("FAIL clr_cursor: row=%0d col=%0d expected 0,0", if8.cursor_row, if8.cursor_col);
        end
    endtask

    task automatic test_rows1();
        logic [8:0] exp_q [$];
        int bad;
        tests++;
        if (q1_data.size() < 1 || {q1_rs[0], q1_data[0]} !== 9'h030) begin
            failed++; $display("FAIL rows1_func: %0d pulses, first not rs=0 data=30", q1_data.size());
        end
        q1_data.delete(); q1_rs.delete();
        for (int i = 0; i < 8; i++) begin
            send1(8'h41 + 8'(i));
            exp_q.push_back({1'b1, 8'h41 + 8'(i)});
            if (i == 6 || i == 7) begin
                tests++;
                if ({if1.cursor_row, if1.cursor_col} !== ((i == 6) ? 4'h7 : 4'h0)) begin
                    failed++; $display("FAIL rows1_cursor%0d: row=%0d col=%0d", i, if1.cursor_row, if1.cursor_col);
                end
            end
        end
`ifdef LCD_AUTO_WRAP_EN
        exp_q.push_back({1'b0, 8'h80});
`endif
        bad = (q1_data.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < exp_q.size(); i++) if ({q1_rs[i], q1_data[i]} !== exp_q[i]) bad++;
        tests++;
        if (bad != 0) begin failed++; $display("FAIL rows1_seq: %0d pulses, %0d errors, expected %0d pulses", q1_data.size(), bad, exp_q.size()); end
    endtask

    task automatic test_reset_midwrite();
        int n, bad;
        @(negedge clk);
        if8.char_in = 8'h42; if8.write = 1'b1;
        @(negedge clk);
        if8.write = 1'b0;
        n = 0;
        while (lcd_e8 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        tests++;
        if ({lcd_e8, lcd_rs8, lcd_data8} !== {1'b1, 1'b1, 8'h42}) begin
            failed++; $display("FAIL rst_pre_e: e/rs/data=%b/%b/%02h expected 1/1/42", lcd_e8, lcd_rs8, lcd_data8);
        end
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        tests++;
        if ({lcd_e8, lcd_rs8, lcd_rw8, if8.busy, lcd_data8} !== {4'b0001, 8'h00}) begin
            failed++; $display("FAIL rst_outputs: e/rs/rw/busy=%b data=%02h expected 0001/00", {lcd_e8, lcd_rs8, lcd_rw8, if8.busy}, lcd_data8);
        end
        tests++;
        if ({if8.cursor_row, if8.cursor_col} !== 5'h00) begin
            failed++; $display("FAIL rst_cursor: row=%0d col=%0d expected 0,0", if8.cursor_row, if8.cursor_col);
        end
        bad = 0;
        repeat (40000) begin
            @(negedge clk);
            if (lcd_e8 !== 1'b0 || if8.busy !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL rst_pwr_wait: %0d bad cycles expected 0", bad); end
        @(negedge clk);
        tests++;
        if ({lcd_e8, lcd_rs8, lcd_data8} !== {1'b1, 1'b0, 8'h38}) begin
            failed++; $display("FAIL rst_restart: e/rs/data=%b/%b/%02h expected 1/0/38", lcd_e8, lcd_rs8, lcd_data8);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_4bit();
        test_wrap();
        test_clear_priority();
        test_rows1();
        test_reset_midwrite();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
